box_motion_ctrl: RTL and testbench
==================================

Name: box_motion_ctrl

Overview: Frame-synchronous position controller for the outlined-box line drawer. It holds the four box edge coordinates (left/right columns, top/bottom rows) and updates them once per frame, during vertical blanking, from debounced button levels (manual mode) or a bouncing-velocity engine (auto mode). The edge coordinates feed the drawer's compare logic directly, so they must never change during active video.

Parameters:
H_ACTIVE, 1024, visible pixels per line; the valid column range is 0..H_ACTIVE-1.
V_ACTIVE, 768, visible lines per frame; the valid row range is 0..V_ACTIVE-1.
INIT_LEFT, 200, left edge column at reset and on recenter.
INIT_RIGHT, 440, right edge column at reset and on recenter.
INIT_TOP, 100, top edge row at reset and on recenter.
INIT_BOTTOM, 580, bottom edge row at reset and on recenter.
STEP, 4, pixels moved per frame on each axis.

Ports:
vclock_in  input  1  pixel clock; all logic is clocked on its rising edge.
rst_n_in  input  1  asynchronous, active-low reset.
hcount_in  input  12  current pixel column.
vcount_in  input  11  current line.
btn_left_in / btn_right_in / btn_up_in / btn_down_in  input  1 each  debounced level inputs; 1 = pressed.
auto_in  input  1  mode select: 1 = bounce mode, 0 = manual mode.
recenter_in  input  1  request to return the box to its initial position; any assertion is latched.
left_out / right_out  output  12 each  box column edges.
top_out / bottom_out  output  11 each  box row edges.
update_out  output  1  one-cycle pulse in the cycle the edge outputs take new values.

Behaviour:
- Reset (async assert): edge outputs = INIT_* values, update_out=0, dir_x=+1, dir_y=+1, recenter_pend=0, state=IDLE.
- Box width W=INIT_RIGHT-INIT_LEFT and height Hh=INIT_BOTTOM-INIT_TOP are constant. right_out=left_out+W and bottom_out=top_out+Hh at all times.
- frame_tick: one-cycle pulse on the rising edge of the condition (vcount_in==V_ACTIVE && hcount_in==0). It fires exactly once per frame even if hcount_in stalls.
- recenter_pend: set by recenter_in in any cycle; cleared only in COMMIT.
- FSM states are IDLE, CALC, CLAMP, COMMIT; each non-IDLE state lasts one cycle.
- IDLE waits for frame_tick; on frame_tick go to CALC.
- CALC latches the mode and button levels sampled at that cycle, then computes candidate positions nx=left+dx and ny=top+dy.
- All candidate arithmetic is 14-bit signed, so negative candidates are representable.
- Manual mode, dx: -STEP if left only, +STEP if right only, 0 if both or neither. dy uses the same rule with up = -STEP and down = +STEP.
- Auto mode: dx=dir_x*STEP, dy=dir_y*STEP; the buttons are ignored.
- CLAMP: if nx<0, nx=0; if nx>H_ACTIVE-1-W, nx=H_ACTIVE-1-W. Apply the same rule to ny with V_ACTIVE-1-Hh.
- In auto mode, any clamp on an axis inverts that axis's direction. A candidate landing exactly on a limit also inverts the direction.
- COMMIT: load the edge outputs (recenter_pend=1 overrides this — see below), pulse update_out for one cycle, return to IDLE.
- Recenter in COMMIT: if recenter_pend=1, the edges take INIT_*, dir_x/dir_y are set to +1, and the computed move is discarded. recenter_pend is then cleared.
- Recenter asserted during CALC/CLAMP/COMMIT of the same frame still sets recenter_pend. If it was not already applied in this COMMIT, it takes effect at the next frame's COMMIT.
- Update latency: edges change exactly 3 cycles after frame_tick, which is inside vertical blanking. The outputs are stable for all active pixels.
- Outputs change only in the COMMIT cycle or on reset.
- A frame_tick arriving while not in IDLE is ignored; this cannot happen with legal timing.
- Reset asserted mid-sequence aborts the sequence; the outputs return to INIT_* immediately (asynchronously).

Test Plan:
- Reset, auto_in=1, run 1 frame -> left_out=204, right_out=444, top_out=104, bottom_out=584; update_out high for 1 cycle, 3 cycles after frame_tick.
- Auto mode, let the box run into the right edge -> left_out stops at 783 (right_out=1023) and dir_x flips. The next frame gives left_out=779. Verify on the bottom edge the same way: top_out reaches 287, then 283.
- Manual mode, left=2, hold btn_left_in -> left_out=0 after 1 frame and stays 0. With btn_left_in and btn_right_in both held -> no change.
- Pulse recenter_in for 1 cycle mid-frame with the box at (600,200) -> at the next COMMIT the edges equal 200/440/100/580 and recenter_pend reads 0.
- Toggle buttons during active video, then check every pixel of lines 0..767 -> the edge outputs never change outside the COMMIT cycle.
- Assert rst_n_in low in the CLAMP cycle -> the outputs take INIT values asynchronously, update_out=0, and the FSM resumes normally at the next frame.

Source files
------------

// File: rtl/box_motion_ctrl_if.sv
// Pixel-timing inputs, button/mode controls and box-edge outputs of the box motion controller.
// The controller sits on the slave side. The video timing and button source sits on the master side.
interface box_motion_ctrl_if;
    logic [11:0] hcount_in;
    logic [10:0] vcount_in;
    logic        btn_left_in;
    logic        btn_right_in;
    logic        btn_up_in;
    logic        btn_down_in;
    logic        auto_in;
    logic        recenter_in;
    logic [11:0] left_out;
    logic [11:0] right_out;
    logic [10:0] top_out;
    logic [10:0] bottom_out;
    logic        update_out;

    modport master (
        output hcount_in, vcount_in, btn_left_in, btn_right_in, btn_up_in, btn_down_in,
               auto_in, recenter_in,
        input  left_out, right_out, top_out, bottom_out, update_out
    );

    modport slave (
        input  hcount_in, vcount_in, btn_left_in, btn_right_in, btn_up_in, btn_down_in,
               auto_in, recenter_in,
        output left_out, right_out, top_out, bottom_out, update_out
    );
endinterface

// File: rtl/box_motion_ctrl.sv
// Frame-synchronous box edge controller: once per frame, in vertical blanking, it moves the box
// by button levels (manual mode) or by a bouncing velocity (auto mode).
module box_motion_ctrl #(
    parameter int H_ACTIVE    = 1024,
    parameter int V_ACTIVE    = 768,
    parameter int INIT_LEFT   = 200,
    parameter int INIT_RIGHT  = 440,
    parameter int INIT_TOP    = 100,
    parameter int INIT_BOTTOM = 580,
    parameter int STEP        = 4
) (
    input  logic             vclock_in,
    input  logic             rst_n_in,
    box_motion_ctrl_if.slave bus
);
    localparam int                 BOX_W   = INIT_RIGHT - INIT_LEFT;
    localparam int                 BOX_H   = INIT_BOTTOM - INIT_TOP;
    localparam logic [11:0]        W_U     = 12'(BOX_W);
    localparam logic [10:0]        H_U     = 11'(BOX_H);
    localparam logic [11:0]        LEFT0   = 12'(INIT_LEFT);
    localparam logic [10:0]        TOP0    = 11'(INIT_TOP);
    localparam logic [11:0]        X_MAX_U = 12'(H_ACTIVE - 1 - BOX_W);
    localparam logic [10:0]        Y_MAX_U = 11'(V_ACTIVE - 1 - BOX_H);
    localparam logic signed [13:0] X_MAX_S = 14'(H_ACTIVE - 1 - BOX_W);
    localparam logic signed [13:0] Y_MAX_S = 14'(V_ACTIVE - 1 - BOX_H);
    localparam logic signed [13:0] STEP_S  = 14'(STEP);
    localparam logic [10:0]        V_TICK  = 11'(V_ACTIVE);

    typedef enum logic [1:0] {IDLE, CALC, CLAMP, COMMIT} state_t;

    state_t             state_q;
    logic               tick_cond_q;
    logic [11:0]        left_q;
    logic [10:0]        top_q;
    logic               dir_x_q, dir_y_q;        // 1 = moving towards larger coordinates
    logic               recenter_pend_q;
    logic               update_q;
    logic               auto_q;
    logic signed [13:0] nx_q, ny_q;

    logic               tick_cond, frame_tick;
    logic signed [13:0] dx, dy, nx_d, ny_d;
    logic [11:0]        cx;
    logic [10:0]        cy;
    logic               hit_x, hit_y;

    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves one unassigned (no latch).
        tick_cond  = (bus.vcount_in == V_TICK) && (bus.hcount_in == '0);
        frame_tick = tick_cond && !tick_cond_q;

        dx = '0;
        dy = '0;
        if (bus.auto_in) begin
            dx = dir_x_q ? STEP_S : -STEP_S;
            dy = dir_y_q ? STEP_S : -STEP_S;
        end else begin
            if (bus.btn_left_in && !bus.btn_right_in) dx = -STEP_S;
            else if (bus.btn_right_in && !bus.btn_left_in) dx = STEP_S;
            if (bus.btn_up_in && !bus.btn_down_in) dy = -STEP_S;
            else if (bus.btn_down_in && !bus.btn_up_in) dy = STEP_S;
        end
        nx_d = $signed({2'b00, left_q}) + dx;
        ny_d = $signed({3'b000, top_q}) + dy;

        // Landing exactly on a limit counts as a hit, so auto mode bounces off it.
        cx    = nx_q[11:0];
        hit_x = 1'b0;
        if (nx_q <= 14'sd0) begin
            cx    = '0;
            hit_x = 1'b1;
        end else if (nx_q >= X_MAX_S) begin
            cx    = X_MAX_U;
            hit_x = 1'b1;
        end
        cy    = ny_q[10:0];
        hit_y = 1'b0;
        if (ny_q <= 14'sd0) begin
            cy    = '0;
            hit_y = 1'b1;
        end else if (ny_q >= Y_MAX_S) begin
            cy    = Y_MAX_U;
            hit_y = 1'b1;
        end
    end

    // NOTE: async reset returns the edges to their initial values immediately; state uses <= only.
    always_ff @(posedge vclock_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q         <= IDLE;
            tick_cond_q     <= 1'b0;
            left_q          <= LEFT0;
            top_q           <= TOP0;
            dir_x_q         <= 1'b1;
            dir_y_q         <= 1'b1;
            recenter_pend_q <= 1'b0;
            update_q        <= 1'b0;
            auto_q          <= 1'b0;
            nx_q            <= '0;
            ny_q            <= '0;
        end else begin
            tick_cond_q <= tick_cond;
            update_q    <= 1'b0;
            // The pending request is consumed on entry to COMMIT; a new request in that same cycle survives.
            recenter_pend_q <= bus.recenter_in || (recenter_pend_q && (state_q != CLAMP));
            case (state_q)
                IDLE: begin
                    if (frame_tick) state_q <= CALC;
                end
                CALC: begin
                    auto_q  <= bus.auto_in;
                    nx_q    <= nx_d;
                    ny_q    <= ny_d;
                    state_q <= CLAMP;
                end
                CLAMP: begin
                    // Edges are registered here, so they show their new values during the COMMIT cycle.
                    if (recenter_pend_q) begin
                        left_q  <= LEFT0;
                        top_q   <= TOP0;
                        dir_x_q <= 1'b1;
                        dir_y_q <= 1'b1;
                    end else begin
                        left_q <= cx;
                        top_q  <= cy;
                        if (auto_q && hit_x) dir_x_q <= !dir_x_q;
                        if (auto_q && hit_y) dir_y_q <= !dir_y_q;
                    end
                    update_q <= 1'b1;
                    state_q  <= COMMIT;
                end
                COMMIT: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.left_out   = left_q;
    assign bus.right_out  = left_q + W_U;
    assign bus.top_out    = top_q;
    assign bus.bottom_out = top_q + H_U;
    assign bus.update_out = update_q;
endmodule

// File: tb/tb_box_motion_ctrl.sv
// Scoreboard bench for box_motion_ctrl. The driver queues the expected edges for each frame,
// and a monitor checks them whenever update_out pulses.
module tb_box_motion_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    box_motion_ctrl_if bus ();
    box_motion_ctrl dut (.vclock_in(clk), .rst_n_in(rst_n), .bus(bus.slave));

    typedef struct {
        logic [11:0] l;
        logic [10:0] t;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   bad_changes = 0;

    // Bench reference model of the box position and bounce directions.
    int m_left = 200, m_top = 100, m_dirx = 1, m_diry = 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst_n && bus.update_out === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_update", 32'(sb.size()), 32'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("left", bus.left_out, e.l);
                check("right", bus.right_out, e.l + 12'd240);
                check("top", bus.top_out, e.t);
                check("bottom", bus.bottom_out, e.t + 11'd480);
                check("latency", cyc, e.cyc);
            end
        end
    end

    // Stability monitor: the edges may only move in an update cycle or under reset.
    logic [11:0] p_l, p_r;
    logic [10:0] p_t, p_b;
    bit          p_v = 1'b0;
    always @(negedge clk) begin
        if (!rst_n || bus.update_out === 1'b1 || !p_v) begin
            p_v = 1'b1;
        end else if (bus.left_out !== p_l || bus.right_out !== p_r ||
                     bus.top_out !== p_t || bus.bottom_out !== p_b) begin
            bad_changes++;
        end
        p_l = bus.left_out;
        p_r = bus.right_out;
        p_t = bus.top_out;
        p_b = bus.bottom_out;
    end

    task automatic model_step(input bit a, l, r, u, d);
        int nx, ny;
        nx = m_left + (a ? 4 * m_dirx : ((r ? 4 : 0) - (l ? 4 : 0)));
        ny = m_top + (a ? 4 * m_diry : ((d ? 4 : 0) - (u ? 4 : 0)));
        if (nx < 0) nx = 0;
        if (nx > 783) nx = 783;
        if (ny < 0) ny = 0;
        if (ny > 287) ny = 287;
        if (a && (nx == 0 || nx == 783)) m_dirx = -m_dirx;
        if (a && (ny == 0 || ny == 287)) m_diry = -m_diry;
        m_left = nx;
        m_top  = ny;
    endtask

    task automatic model_recenter();
        m_left = 200;
        m_top  = 100;
        m_dirx = 1;
        m_diry = 1;
    endtask

    // One blanking sequence. rc_off and rst_off are cycle offsets after the tick (-1 = unused).
    // stall holds the tick condition for extra cycles.
    task automatic run_frame(input bit a, l, r, u, d, input int rc_off, input int rst_off,
                             input int stall, input bit push, input int el, input int et);
        @(negedge clk);
        bus.auto_in      = a;
        bus.btn_left_in  = l;
        bus.btn_right_in = r;
        bus.btn_up_in    = u;
        bus.btn_down_in  = d;
        bus.vcount_in    = 11'd767;
        bus.hcount_in    = 12'd1023;
        @(negedge clk);
        bus.vcount_in = 11'd768;
        bus.hcount_in = 12'd0;
        if (push) sb.push_back('{12'(el), 11'(et), cyc + 3});
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i > stall) bus.hcount_in = 12'd1;
            bus.recenter_in = (i == rc_off);
            if (i == rst_off) begin
                #2 rst_n = 1'b0;
                #1;
                check("rst_left", bus.left_out, 32'd200);
                check("rst_right", bus.right_out, 32'd440);
                check("rst_top", bus.top_out, 32'd100);
                check("rst_bottom", bus.bottom_out, 32'd580);
                check("rst_update", bus.update_out, 32'd0);
            end
        end
        if (rst_off > 0) begin
            @(negedge clk);
            rst_n = 1'b1;
        end
    endtask

    // Advance the model, then queue either the model result or a hand-computed key value.
    task automatic step_frame(input bit a, l, r, u, d, input bit key, input int kl, input int kt);
        model_step(a, l, r, u, d);
        run_frame(a, l, r, u, d, -1, -1, 0, 1'b1, key ? kl : m_left, key ? kt : m_top);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        check(name, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.hcount_in    = '0;
        bus.vcount_in    = '0;
        bus.btn_left_in  = 1'b0;
        bus.btn_right_in = 1'b0;
        bus.btn_up_in    = 1'b0;
        bus.btn_down_in  = 1'b0;
        bus.auto_in      = 1'b1;
        bus.recenter_in  = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("reset_left", bus.left_out, 32'd200);
        check("reset_right", bus.right_out, 32'd440);
        check("reset_top", bus.top_out, 32'd100);
        check("reset_bottom", bus.bottom_out, 32'd580);
        check("reset_update", bus.update_out, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Auto bounce. The bottom limit is hit at frame 47, the top at 119 and the right at 146.
        for (int f = 1; f <= 147; f++) begin
            case (f)
                1:       step_frame(1, 0, 0, 0, 0, 1, 204, 104);
                47:      step_frame(1, 0, 0, 0, 0, 1, 388, 287);
                48:      step_frame(1, 0, 0, 0, 0, 1, 392, 283);
                146:     step_frame(1, 0, 0, 0, 0, 1, 783, 108);
                147:     step_frame(1, 0, 0, 0, 0, 1, 779, 112);
                default: step_frame(1, 0, 0, 0, 0, 0, 0, 0);
            endcase
        end
        drain("drain_auto");

        // Manual left from 779: 3 after 194 frames, then -1 clamps to 0 and stays there.
        for (int f = 1; f <= 196; f++)
            step_frame(0, 1, 0, 0, 0, f >= 194, (f == 194) ? 3 : 0, 112);
        step_frame(0, 1, 1, 0, 0, 1, 0, 112);
        step_frame(0, 0, 1, 0, 0, 1, 4, 112);
        step_frame(0, 0, 0, 0, 1, 1, 4, 116);
        step_frame(0, 0, 0, 1, 1, 1, 4, 116);
        for (int f = 1; f <= 43; f++) step_frame(0, 0, 0, 0, 1, f == 43, 4, 287);
        step_frame(0, 0, 0, 0, 1, 1, 4, 287);
        drain("drain_manual");

        // Buttons toggle through active video; no edge may move.
        for (int v = 0; v < 4; v++) begin
            for (int h = 0; h < 1024; h++) begin
                @(negedge clk);
                bus.vcount_in    = 11'(v);
                bus.hcount_in    = 12'(h);
                bus.btn_left_in  = 1'($urandom_range(1));
                bus.btn_right_in = 1'($urandom_range(1));
                bus.btn_up_in    = 1'($urandom_range(1));
                bus.btn_down_in  = 1'($urandom_range(1));
            end
        end
        step_frame(0, 0, 1, 0, 0, 1, 8, 287);

        // Recenter pulse in active video wins over the held right button at the next commit.
        @(negedge clk);
        bus.vcount_in   = 11'd100;
        bus.hcount_in   = 12'd50;
        bus.recenter_in = 1'b1;
        @(negedge clk);
        bus.recenter_in = 1'b0;
        check("pend_set", dut.recenter_pend_q, 32'd1);
        model_recenter();
        run_frame(0, 0, 1, 0, 0, -1, -1, 0, 1'b1, 200, 100);
        check("pend_clear", dut.recenter_pend_q, 32'd0);

        // A recenter in the CLAMP cycle misses this commit and lands on the next one.
        model_step(0, 0, 1, 0, 0);
        run_frame(0, 0, 1, 0, 0, 2, -1, 0, 1'b1, 204, 100);
        model_recenter();
        run_frame(0, 0, 1, 0, 0, -1, -1, 0, 1'b1, 200, 100);
        check("pend_clear2", dut.recenter_pend_q, 32'd0);

        // After a recenter both directions are +1 again.
        step_frame(1, 0, 0, 0, 0, 1, 204, 104);
        drain("drain_recenter");

        // Reset in the CLAMP cycle aborts the move; the next frame proceeds from INIT.
        run_frame(1, 0, 0, 0, 0, -1, 2, 0, 1'b0, 0, 0);
        model_recenter();
        step_frame(1, 0, 0, 0, 0, 1, 204, 104);

        // A tick condition held for three cycles must still give exactly one update.
        model_step(1, 0, 0, 0, 0);
        run_frame(1, 0, 0, 0, 0, -1, -1, 2, 1'b1, 208, 108);
        repeat (10) @(negedge clk);
        drain("drain_final");
        check("edge_stability", bad_changes, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
